// File: rtl/drsw_ram_req_ctrl_pkg.sv
// Shared definitions for the port-0 RAM request controller: FSM state
// encoding and response FIFO geometry.
package drsw_ram_req_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_DRAIN = 2'd3
    } state_t;

    localparam int RSP_FIFO_DEPTH = 4;
    localparam int RSP_PTR_W      = $clog2(RSP_FIFO_DEPTH);
    // Count must be able to hold DEPTH itself, plus headroom for the
    // in-flight beats added on top of it in the credit sum.
    localparam int RSP_CNT_W      = RSP_PTR_W + 1;

endpackage

// File: rtl/drsw_rsp_fifo.sv
// Small synchronous FIFO holding returned read beats ({last,data}) until
// the consumer takes them. Head is presented combinationally from storage.
module drsw_rsp_fifo
    import drsw_ram_req_ctrl_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_push_data,
    input  logic                 i_pop,
    output logic [WIDTH-1:0]     o_head,
    output logic [RSP_CNT_W-1:0] o_count,
    output logic                 o_full,
    output logic                 o_empty
);

    logic [WIDTH-1:0]     r_mem [RSP_FIFO_DEPTH];
    logic [RSP_PTR_W-1:0] r_wr_ptr;
    logic [RSP_PTR_W-1:0] r_rd_ptr;
    logic [RSP_CNT_W-1:0] r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == RSP_CNT_W'(RSP_FIFO_DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage: cleared on reset so no stale beat survives an aborted burst.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + RSP_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + RSP_PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + RSP_CNT_W'(1);
                2'b01:   r_count <= r_count - RSP_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/drsw_ram_req_ctrl.sv
// Requester-side controller for RAM port 0: turns single writes and
// incrementing read bursts into registered address/data/rnw drive, and
// returns read beats through a credit-protected response FIFO.
module drsw_ram_req_ctrl
    import drsw_ram_req_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 8,
    parameter int LEN_WIDTH      = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rnw,
    input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]      req_len,
    input  logic [MEM_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [MEM_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_last,
    output logic [MEM_ADDR_WIDTH-1:0] ram_address0,
    output logic [MEM_DATA_WIDTH-1:0] ram_data_in0,
    output logic                      ram_rnw0,
    input  logic [MEM_DATA_WIDTH-1:0] ram_data_out0
);

    state_t                    r_state, w_state_next;
    logic [MEM_ADDR_WIDTH-1:0] r_address, w_address_next;
    logic [MEM_DATA_WIDTH-1:0] r_data_in, w_data_in_next;
    logic                      r_rnw, w_rnw_next;
    logic [MEM_ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_next;
    logic [LEN_WIDTH-1:0]      r_remaining, w_remaining_next;
    logic                      r_iss_v, w_iss_v_next;
    logic                      r_iss_last, w_iss_last_next;
    logic                      r_dat_v;
    logic                      r_dat_last;

    logic                      w_accept;
    logic                      w_credit;
    logic [RSP_CNT_W-1:0]      w_used;
    logic [MEM_DATA_WIDTH:0]   w_head;
    logic [RSP_CNT_W-1:0]      w_fifo_count;
    logic                      w_full;
    logic                      w_empty;

    // Gated by reset_n so the request side reads not-ready while held in reset.
    assign req_ready    = (r_state == ST_IDLE) & reset_n;
    assign w_accept     = req_valid & req_ready;
    assign ram_address0 = r_address;
    assign ram_data_in0 = r_data_in;
    assign ram_rnw0     = r_rnw;

    // Beats on the RAM address bus, beats on the RAM data bus and beats
    // already buffered together may never exceed the FIFO depth.
    assign w_used   = RSP_CNT_W'(r_iss_v) + RSP_CNT_W'(r_dat_v) + w_fifo_count;
    assign w_credit = (w_used < RSP_CNT_W'(RSP_FIFO_DEPTH)) & ~w_full;

    assign rsp_valid = ~w_empty;
    assign rsp_rdata = w_empty ? '0 : w_head[MEM_DATA_WIDTH-1:0];
    assign rsp_last  = ~w_empty & w_head[MEM_DATA_WIDTH];

    drsw_rsp_fifo #(
        .WIDTH (MEM_DATA_WIDTH + 1)
    ) u_rsp_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_push      (r_dat_v),
        .i_push_data ({r_dat_last, ram_data_out0}),
        .i_pop       (rsp_valid & rsp_ready),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Next-state and next-drive decode; rnw returns to read unless a write is launched.
    always_comb begin
        w_state_next     = r_state;
        w_address_next   = r_address;
        w_data_in_next   = r_data_in;
        w_rnw_next       = 1'b1;
        w_rd_addr_next   = r_rd_addr;
        w_remaining_next = r_remaining;
        w_iss_v_next     = 1'b0;
        w_iss_last_next  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_address_next = req_addr;
                    if (!req_rnw) begin
                        w_data_in_next = req_wdata;
                        w_rnw_next     = 1'b0;
                        w_state_next   = ST_WRITE;
                    end else begin
                        // First beat issues on the accept edge itself.
                        w_rd_addr_next   = req_addr + MEM_ADDR_WIDTH'(1);
                        w_remaining_next = req_len;
                        w_iss_v_next     = 1'b1;
                        w_iss_last_next  = (req_len == '0);
                        w_state_next     = (req_len == '0) ? ST_RD_DRAIN : ST_RD_ISSUE;
                    end
                end
            end
            ST_WRITE: begin
                w_state_next = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                if (w_credit) begin
                    w_address_next   = r_rd_addr;
                    w_rd_addr_next   = r_rd_addr + MEM_ADDR_WIDTH'(1);
                    w_remaining_next = r_remaining - LEN_WIDTH'(1);
                    w_iss_v_next     = 1'b1;
                    w_iss_last_next  = (r_remaining == LEN_WIDTH'(1));
                    if (r_remaining == LEN_WIDTH'(1)) begin
                        w_state_next = ST_RD_DRAIN;
                    end
                end
            end
            ST_RD_DRAIN: begin
                if (!r_iss_v && !r_dat_v && w_empty) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // RAM drive registers and the two-stage read-return tracking pipeline.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_address   <= '0;
            r_data_in   <= '0;
            r_rnw       <= 1'b1;
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_iss_v     <= 1'b0;
            r_iss_last  <= 1'b0;
            r_dat_v     <= 1'b0;
            r_dat_last  <= 1'b0;
        end else begin
            r_address   <= w_address_next;
            r_data_in   <= w_data_in_next;
            r_rnw       <= w_rnw_next;
            r_rd_addr   <= w_rd_addr_next;
            r_remaining <= w_remaining_next;
            r_iss_v     <= w_iss_v_next;
            r_iss_last  <= w_iss_last_next;
            r_dat_v     <= r_iss_v;
            r_dat_last  <= r_iss_last;
        end
    end

endmodule
